// File: rtl/ram_2x4kb_arbiter_pkg.sv
// ---------------------------------------------------------------
// ram_2x4kb_arbiter_pkg : shared constants for the 2x4KB RAM arbiter
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package ram_2x4kb_arbiter_pkg;
  localparam int unsigned RAM_AW   = 11;
  localparam int unsigned RAM_DW   = 32;
  localparam int unsigned BANK_BIT = RAM_AW - 1;

  typedef logic port_t;
  localparam port_t P0 = 1'b0;
  localparam port_t P1 = 1'b1;
endpackage

`default_nettype wire

// File: rtl/ram_2x4kb_arbiter_rr_arb2.sv
// ---------------------------------------------------------------
// ram_2x4kb_arbiter_rr_arb2 : two-input round-robin / fixed-priority picker
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module ram_2x4kb_arbiter_rr_arb2
  import ram_2x4kb_arbiter_pkg::*;
#(
  parameter bit RR = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  input  port_t      i_acc_port,
  output logic       o_any,
  output logic       o_both,
  output port_t      o_win
);

  logic r_ptr;

  assign o_any  = |i_req;
  assign o_both = &i_req;

  always_comb begin
    o_win = P0;
    if (o_both) begin
      o_win = RR ? r_ptr : P0;
    end else if (i_req[1]) begin
      o_win = P1;
    end
  end

  // The pointer moves to the port that did not get the access just granted.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ptr <= P0;
    end else if (i_accept) begin
      r_ptr <= ~i_acc_port;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_2x4kb_arbiter.sv
// ---------------------------------------------------------------
// ram_2x4kb_arbiter : two requesters sharing one banked 2x1Kx32 RAM
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module ram_2x4kb_arbiter
  import ram_2x4kb_arbiter_pkg::*;
#(
  parameter int unsigned AW = RAM_AW,
  parameter int unsigned DW = RAM_DW,
  parameter bit          RR = 1'b1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            req0,
  input  logic            req1,
  input  logic [DW/8-1:0] we0,
  input  logic [DW/8-1:0] we1,
  input  logic [AW-1:0]   a0,
  input  logic [AW-1:0]   a1,
  input  logic [DW-1:0]   di0,
  input  logic [DW-1:0]   di1,
  output logic            gnt0,
  output logic            gnt1,
  output logic            rvalid0,
  output logic            rvalid1,
  output logic [DW-1:0]   do0,
  output logic [DW-1:0]   do1,
  output logic            ram_en,
  output logic [DW/8-1:0] ram_we,
  output logic [AW-1:0]   ram_a,
  output logic [DW-1:0]   ram_di,
  input  logic [DW-1:0]   ram_do
);

  logic [AW-1:0]   w_a  [2];
  logic [DW/8-1:0] w_we [2];
  logic [DW-1:0]   w_di [2];

  assign w_a[0]  = a0;
  assign w_a[1]  = a1;
  assign w_we[0] = we0;
  assign w_we[1] = we1;
  assign w_di[0] = di0;
  assign w_di[1] = di1;

  logic [AW-1:0] r_last_a;
  logic          r_rd_pend;
  port_t         r_rd_port;

  logic  w_any, w_both;
  port_t w_win, w_lose, w_gport;
  logic  w_win_ok, w_lose_ok, w_gnt_vld;

  ram_2x4kb_arbiter_rr_arb2 #(.RR(RR)) u_arb (
    .CLK        (CLK),
    .RST        (RST),
    .i_req      ({req1, req0}),
    .i_accept   (w_gnt_vld),
    .i_acc_port (w_gport),
    .o_any      (w_any),
    .o_both     (w_both),
    .o_win      (w_win)
  );

  // The RAM output mux follows the live bank bit, so while a read is
  // returning only accesses to the same bank may be issued.
  assign w_lose    = ~w_win;
  assign w_win_ok  = !r_rd_pend || (w_a[w_win][AW-1] == r_last_a[AW-1]);
  assign w_lose_ok = w_both && (!r_rd_pend || (w_a[w_lose][AW-1] == r_last_a[AW-1]));
  assign w_gnt_vld = !RST && w_any && (w_win_ok || w_lose_ok);
  assign w_gport   = w_win_ok ? w_win : w_lose;

  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    ram_en = 1'b0;
    ram_we = '0;
    ram_a  = r_last_a;
    ram_di = '0;
    if (w_gnt_vld) begin
      gnt0   = (w_gport == P0);
      gnt1   = (w_gport == P1);
      ram_en = 1'b1;
      ram_we = w_we[w_gport];
      ram_a  = w_a[w_gport];
      ram_di = w_di[w_gport];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_last_a  <= '0;
      r_rd_pend <= 1'b0;
      r_rd_port <= P0;
    end else if (w_gnt_vld) begin
      r_last_a  <= ram_a;
      r_rd_pend <= (ram_we == '0);
      r_rd_port <= w_gport;
    end else begin
      r_rd_pend <= 1'b0;
    end
  end

  // Gating with RST drops a read granted in the cycle just before reset.
  assign rvalid0 = r_rd_pend && !RST && (r_rd_port == P0);
  assign rvalid1 = r_rd_pend && !RST && (r_rd_port == P1);
  assign do0     = ram_do;
  assign do1     = ram_do;

endmodule

`default_nettype wire

// File: tb/tb_ram_2x4kb_arbiter.sv
// ---------------------------------------------------------------
// tb_ram_2x4kb_arbiter : directed bench with read-return scoreboard
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_ram_2x4kb_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req0, req1;
  logic [3:0]  we0, we1;
  logic [10:0] a0, a1;
  logic [31:0] di0, di1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] do0, do1;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [10:0] ram_a;
  logic [31:0] ram_di, ram_do;

  logic        fp_req0, fp_req1;
  logic        fp_gnt0, fp_gnt1, fp_rvalid0, fp_rvalid1;
  logic [31:0] fp_do0, fp_do1, fp_ram_di;
  logic        fp_ram_en;
  logic [3:0]  fp_ram_we;
  logic [10:0] fp_ram_a;

  always #5 CLK = ~CLK;

  ram_2x4kb_arbiter #(.AW(11), .DW(32), .RR(1'b1)) u_dut (
    .CLK(CLK), .RST(RST),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .a0(a0), .a1(a1), .di0(di0), .di1(di1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .do0(do0), .do1(do1),
    .ram_en(ram_en), .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di),
    .ram_do(ram_do)
  );

  ram_2x4kb_arbiter #(.AW(11), .DW(32), .RR(1'b0)) u_dut_fp (
    .CLK(CLK), .RST(RST),
    .req0(fp_req0), .req1(fp_req1), .we0(4'h0), .we1(4'h0),
    .a0(11'h010), .a1(11'h011), .di0(32'h0), .di1(32'h0),
    .gnt0(fp_gnt0), .gnt1(fp_gnt1), .rvalid0(fp_rvalid0), .rvalid1(fp_rvalid1),
    .do0(fp_do0), .do1(fp_do1),
    .ram_en(fp_ram_en), .ram_we(fp_ram_we), .ram_a(fp_ram_a), .ram_di(fp_ram_di),
    .ram_do(32'h0)
  );

  // Banked RAM: each bank registers its own read word; output mux uses live ram_a[10].
  logic [31:0] mem [2048];
  logic [31:0] q0, q1;

  always @(posedge CLK) begin
    if (ram_en) begin
      if (ram_we != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (ram_we[b]) mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
      end else if (ram_a[10]) begin
        q1 <= mem[ram_a];
      end else begin
        q0 <= mem[ram_a];
      end
    end
  end
  assign ram_do = ram_a[10] ? q1 : q0;

  typedef struct {
    logic        port;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic port, input logic [31:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    e.due  = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_reqs();
    req0 = 1'b0; req1 = 1'b0;
    we0 = 4'h0; we1 = 4'h0;
    a0 = 11'h0; a1 = 11'h0;
    di0 = 32'h0; di1 = 32'h0;
  endtask

  task automatic idle(input int n);
    clear_reqs();
    repeat (n) begin
      @(negedge CLK);
      step();
    end
  endtask

  // Monitor: pops one expected read per rvalid, flags late/missing returns.
  always @(negedge CLK) begin
    exp_t e;
    if (rvalid0 || rvalid1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rvalid_unexpected: got rvalid=%b%b expected none (cycle %0d)",
                 rvalid1, rvalid0, cyc);
      end else begin
        e = sb.pop_front();
        chk("rvalid_port", {30'h0, rvalid1, rvalid0}, e.port ? 32'h2 : 32'h1);
        chk("rdata", e.port ? do1 : do0, e.data);
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL rvalid_missing: got none expected port%0d data %h (cycle %0d)",
               e.port, e.data, cyc);
    end
  end

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    mem[11'h005] = 32'hDEADBEEF;
    mem[11'h010] = 32'h0000_1010;
    mem[11'h011] = 32'h0000_1111;
    mem[11'h003] = 32'h3333_0003;
    mem[11'h403] = 32'h4444_0403;
    mem[11'h7FF] = 32'h1122_3344;
    q0 = 32'h0;
    q1 = 32'h0;

    // Reset with requests pending: nothing may reach the RAM.
    RST = 1'b1;
    fp_req0 = 1'b0; fp_req1 = 1'b0;
    clear_reqs();
    req0 = 1'b1; a0 = 11'h005;
    req1 = 1'b1; we1 = 4'hF; a1 = 11'h007; di1 = 32'h5555_5555;
    step(); step();
    @(negedge CLK);
    chk("rst_gnt0", gnt0, 1'b0);
    chk("rst_gnt1", gnt1, 1'b0);
    chk("rst_ram_en", ram_en, 1'b0);
    chk("rst_ram_we", ram_we, 4'h0);
    chk("rst_ram_a", ram_a, 11'h0);
    chk("rst_ram_di", ram_di, 32'h0);
    chk("rst_rvalid", {rvalid1, rvalid0}, 2'b00);
    step();
    RST = 1'b0;
    idle(1);

    // Single read from port 0.
    req0 = 1'b1; a0 = 11'h005;
    @(negedge CLK);
    chk("t1_gnt0", gnt0, 1'b1);
    chk("t1_gnt1", gnt1, 1'b0);
    chk("t1_ram_a", ram_a, 11'h005);
    chk("t1_ram_en", ram_en, 1'b1);
    push(1'b0, 32'hDEADBEEF);
    step();
    idle(2);

    // Round-robin alternation, starting from port 0 after reset.
    RST = 1'b1;
    @(negedge CLK);
    step();
    RST = 1'b0;
    req0 = 1'b1; a0 = 11'h010;
    req1 = 1'b1; a1 = 11'h011;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("t2_gnt0", gnt0, (i % 2) == 0);
      chk("t2_gnt1", gnt1, (i % 2) == 1);
      push((i % 2) == 1, ((i % 2) == 1) ? 32'h0000_1111 : 32'h0000_1010);
      step();
    end
    idle(2);

    // Bank hazard: port 1 read to bank 1 must wait out port 0's bank-0 return.
    req0 = 1'b1; a0 = 11'h003;
    @(negedge CLK);
    chk("t3_gnt0", gnt0, 1'b1);
    push(1'b0, 32'h3333_0003);
    step();
    req0 = 1'b0;
    req1 = 1'b1; a1 = 11'h403;
    @(negedge CLK);
    chk("t3_stall_gnt1", gnt1, 1'b0);
    chk("t3_stall_ram_a", ram_a, 11'h003);
    chk("t3_stall_ram_en", ram_en, 1'b0);
    step();
    @(negedge CLK);
    chk("t3_gnt1", gnt1, 1'b1);
    chk("t3_ram_a", ram_a, 11'h403);
    push(1'b1, 32'h4444_0403);
    step();
    idle(2);

    // Partial write (bytes 0 and 2) then read back.
    req1 = 1'b1; we1 = 4'b0101; a1 = 11'h7FF; di1 = 32'hAABBCCDD;
    @(negedge CLK);
    chk("t4_wr_gnt1", gnt1, 1'b1);
    chk("t4_ram_we", ram_we, 4'b0101);
    chk("t4_ram_di", ram_di, 32'hAABBCCDD);
    chk("t4_ram_a", ram_a, 11'h7FF);
    step();
    we1 = 4'h0;
    @(negedge CLK);
    chk("t4_rd_gnt1", gnt1, 1'b1);
    push(1'b1, 32'h11BB33DD);
    step();
    idle(2);

    // Fixed priority instance: port 1 starves while port 0 requests.
    fp_req0 = 1'b1; fp_req1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("t5_fp_gnt0", fp_gnt0, 1'b1);
      chk("t5_fp_gnt1", fp_gnt1, 1'b0);
      step();
    end
    fp_req0 = 1'b0;
    @(negedge CLK);
    chk("t5_fp_gnt1_alone", fp_gnt1, 1'b1);
    step();
    fp_req1 = 1'b0;

    // Read granted right before reset: its return is dropped.
    req0 = 1'b1; a0 = 11'h005;
    @(negedge CLK);
    chk("t6_gnt0", gnt0, 1'b1);
    step();
    RST = 1'b1;
    req1 = 1'b1; we1 = 4'hF; a1 = 11'h006; di1 = 32'h7777_7777;
    @(negedge CLK);
    chk("t6_rst_rvalid0", rvalid0, 1'b0);
    chk("t6_rst_gnt", {gnt1, gnt0}, 2'b00);
    chk("t6_rst_ram_we", ram_we, 4'h0);
    step();
    RST = 1'b0;
    we1 = 4'h0; a1 = 11'h011; di1 = 32'h0;
    @(negedge CLK);
    chk("t6_post_gnt0", gnt0, 1'b1);
    chk("t6_post_gnt1", gnt1, 1'b0);
    push(1'b0, 32'hDEADBEEF);
    step();
    req0 = 1'b0;
    @(negedge CLK);
    chk("t6_post2_gnt1", gnt1, 1'b1);
    push(1'b1, 32'h0000_1111);
    step();
    idle(3);

    chk("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
